harvos_dma_mem_bridge: RTL
==========================

# harvos_dma_mem_bridge

Downstream stage of the DMA firewall. It takes the single forwarded DMA request the firewall emits after its policy check and runs it against the data-RAM port. It returns read data, completion or fault to the firewall's memory-return inputs, which drive the fault reported on the DMA master interface. It also enforces a second RAM-window and alignment check and a response timeout, and keeps a saturating error counter for debug.

## Interface
- RAM_BASE, 32'h0001_0000, byte base of the DMA-reachable RAM window
- RAM_BYTES, 32'd65536, window size in bytes; power of two, ≥4
- TIMEOUT_CYC, 16'd64, maximum cycles a transaction may spend in REQ+WAIT, and the limit in DRAIN
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- fw_req  in  1  forwarded request (level or pulse)
- fw_we  in  1  1 = write
- fw_be  in  4  byte enables
- fw_addr  in  32  byte address
- fw_wdata  in  32  write data
- m_rdata  out  32  read data, valid with m_rvalid
- m_rvalid  out  1  one-cycle completion pulse
- m_fault  out  1  one-cycle fault pulse
- mem_req  out  1  RAM request, held until granted
- mem_we  out  1  RAM write
- mem_be  out  4  RAM byte enables
- mem_addr  out  32  word-aligned RAM byte address
- mem_wdata  out  32  RAM write data
- mem_gnt  in  1  RAM accepts the request this cycle
- mem_rvalid  in  1  RAM completion; reads carry mem_rdata, writes are acknowledged
- mem_rdata  in  32  RAM read data
- busy  out  1  state ≠ IDLE
- err_count  out  16  saturating count of faults
- last_err_addr  out  32  fw_addr of the most recent fault

## Operation
- FSM states: IDLE, REQ, WAIT, RESP, FAULT, DRAIN. All outputs are registered.
- ARMED flag: set at reset. Cleared on capture. Set again in any cycle where fw_req = 0. A request is captured only if fw_req = 1 && ARMED && state = IDLE. This prevents a held fw_req from re-issuing after completion.
- Capture in IDLE: latch we/be/addr/wdata, then check:
  - illegal if addr[1:0] ≠ 0;
  - illegal if be = 0;
  - illegal if addr < RAM_BASE or addr ≥ RAM_BASE + RAM_BYTES. Compute in 33 bits, no wrap.
  - Illegal → FAULT. Legal → REQ.
- REQ: mem_req = 1 with latched fields. mem_gnt = 1 → WAIT. Timer expiry → FAULT with mem_req dropped.
- WAIT: mem_rvalid = 1 → RESP, latching mem_rdata (reads) or 0 (writes). Timer expiry → DRAIN.
- RESP: m_rvalid = 1 for one cycle → IDLE.
- FAULT: m_fault = 1 for one cycle. err_count += 1, saturating at 16'hFFFF. last_err_addr ← latched addr. → IDLE.
- DRAIN: entered after a timeout while granted. Issues m_fault the cycle it is entered (counted as above), then waits for the orphan mem_rvalid, which is discarded, or for TIMEOUT_CYC more cycles → IDLE. No new capture occurs in DRAIN.
- Timer: 16-bit. Cleared on capture; increments each cycle in REQ/WAIT. Expiry means timer == TIMEOUT_CYC − 1 while still in REQ/WAIT. Reused with a fresh clear for the DRAIN limit.
- mem_rvalid outside WAIT/DRAIN is ignored. mem_gnt outside REQ is ignored.
- m_rvalid and m_fault are never high together.

## Timing
- Reset values: all outputs 0 (m_rdata, mem_* buses, err_count, last_err_addr = 0). state = IDLE, ARMED = 1.
- Reset mid-transaction: mem_req drops asynchronously. Any in-flight response is lost; no pulse is emitted.
- Legal read, zero-wait RAM (gnt in first REQ cycle, rvalid the next cycle):
  - cycle 0: capture;
  - cycle 1: mem_req;
  - cycle 2: WAIT with mem_rvalid;
  - cycle 3: m_rvalid.
  - Latency is 3 cycles from capture edge to m_rvalid.
- Illegal request: m_fault in cycle 1. mem_req is never asserted.
- Timeout in REQ: m_fault appears TIMEOUT_CYC+1 cycles after capture.
- Throughput: at most one transaction per 4 cycles, plus the cycle needed to see fw_req low.

## Test plan
- Legal write at 0x0001_0000, be=4'hF, wdata=0xDEADBEEF, gnt/rvalid immediate → mem_addr=0x0001_0000, mem_wdata=0xDEADBEEF, one m_rvalid pulse 3 cycles after capture, m_fault stays 0.
- Read at 0x0001_0010, RAM returns 0x1234_5678 after 2 wait cycles → m_rdata=0x1234_5678 with a single m_rvalid pulse. fw_req held high 5 more cycles → no second mem_req.
- Fault cases, one at a time: write at 0x0000_0004 (I-space), then at 0x0001_0002 (misaligned), then with be=0 → each gives m_fault in cycle 1, mem_req never set. Final state: err_count=3, last_err_addr=the last faulting address.
- mem_gnt held low, TIMEOUT_CYC=8 → m_fault 9 cycles after capture; mem_req low from then on.
- Granted, no rvalid → DRAIN and m_fault. A late mem_rvalid at cycle +3 produces no m_rvalid. The next request completes normally.
- Assert rst in WAIT → mem_req=0, busy=0 immediately; no m_rvalid or m_fault after release.

Source files
------------

// File: rtl/harvos_dma_mem_bridge_if.sv
// Bus bundle between the DMA firewall, the memory bridge and the data-RAM port.
// Groups:
//   fw_*          forwarded request from the firewall (into the bridge)
//   m_*           completion / fault return to the firewall (out of the bridge)
//   mem_*         data-RAM request/response port
//   busy, err_count, last_err_addr  debug status from the bridge
// Modports:
//   slave  - the bridge's view (consumes fw_* and RAM responses, drives the rest)
//   master - the environment's view (firewall + RAM side)
interface harvos_dma_mem_bridge_if;
  logic        fw_req;
  logic        fw_we;
  logic [3:0]  fw_be;
  logic [31:0] fw_addr;
  logic [31:0] fw_wdata;

  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic        m_fault;

  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        busy;
  logic [15:0] err_count;
  logic [31:0] last_err_addr;

  modport slave (
    input  fw_req, fw_we, fw_be, fw_addr, fw_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output m_rdata, m_rvalid, m_fault,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output busy, err_count, last_err_addr
  );

  modport master (
    output fw_req, fw_we, fw_be, fw_addr, fw_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  m_rdata, m_rvalid, m_fault,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  busy, err_count, last_err_addr
  );
endinterface

// File: rtl/harvos_dma_mem_bridge.sv
// DMA firewall -> data-RAM bridge.
// Takes one forwarded request at a time, re-checks RAM window / alignment /
// byte enables, runs it against the RAM port with a response timeout, and
// returns a one-cycle completion (m_rvalid) or fault (m_fault) pulse.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - harvos_dma_mem_bridge_if.slave (fw_*, m_*, mem_*, debug status)
// All outputs are registered.
module harvos_dma_mem_bridge #(
  parameter logic [31:0] RAM_BASE    = 32'h0001_0000,
  parameter logic [31:0] RAM_BYTES   = 32'd65536,
  parameter logic [15:0] TIMEOUT_CYC = 16'd64
) (
  input  logic                    clk,
  input  logic                    rst,
  harvos_dma_mem_bridge_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, FAULT, DRAIN} state_t;

  // Window bounds in 33 bits so BASE+BYTES never wraps.
  localparam logic [32:0] WIN_LO = {1'b0, RAM_BASE};
  localparam logic [32:0] WIN_HI = {1'b0, RAM_BASE} + {1'b0, RAM_BYTES};

  state_t      state_q;
  logic        armed_q;
  logic        busy_q;
  logic        m_rvalid_q;
  logic        m_fault_q;
  logic [31:0] m_rdata_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [15:0] timer_q;
  logic [15:0] err_count_q;
  logic [31:0] last_err_addr_q;

  logic        capture;
  logic        illegal;
  logic        expired;
  logic [32:0] addr_ext;
  logic [15:0] err_count_d;

  always_comb begin
    addr_ext    = {1'b0, bus.fw_addr};
    capture     = bus.fw_req && armed_q && (state_q == IDLE);
    illegal     = (bus.fw_addr[1:0] != 2'b00) || (bus.fw_be == 4'h0) ||
                  (addr_ext < WIN_LO) || (addr_ext >= WIN_HI);
    expired     = (timer_q == TIMEOUT_CYC - 16'd1);
    err_count_d = (err_count_q == '1) ? err_count_q : err_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      armed_q         <= 1'b1;
      busy_q          <= 1'b0;
      m_rvalid_q      <= 1'b0;
      m_fault_q       <= 1'b0;
      m_rdata_q       <= '0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_be_q        <= '0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      timer_q         <= '0;
      err_count_q     <= '0;
      last_err_addr_q <= '0;
    end else begin
      m_rvalid_q <= 1'b0;
      m_fault_q  <= 1'b0;
      // Re-arm only after fw_req has been seen low, so a held level does not re-issue.
      if (!bus.fw_req) armed_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (capture) begin
            armed_q <= 1'b0;
            busy_q  <= 1'b1;
            timer_q <= '0;
            if (illegal) begin
              state_q         <= FAULT;
              m_fault_q       <= 1'b1;
              err_count_q     <= err_count_d;
              last_err_addr_q <= bus.fw_addr;
            end else begin
              state_q     <= REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.fw_we;
              mem_be_q    <= bus.fw_be;
              mem_addr_q  <= {bus.fw_addr[31:2], 2'b00};
              mem_wdata_q <= bus.fw_wdata;
            end
          end
        end

        REQ: begin
          if (bus.mem_gnt || expired) mem_req_q <= 1'b0;
          if (expired) begin
            // A grant on the final cycle still leaves a response in flight: drain it.
            state_q         <= bus.mem_gnt ? DRAIN : FAULT;
            m_fault_q       <= 1'b1;
            err_count_q     <= err_count_d;
            last_err_addr_q <= mem_addr_q;
            timer_q         <= '0;
          end else begin
            if (bus.mem_gnt) state_q <= WAIT;
            timer_q <= timer_q + 16'd1;
          end
        end

        WAIT: begin
          if (bus.mem_rvalid) begin
            state_q    <= RESP;
            m_rvalid_q <= 1'b1;
            m_rdata_q  <= mem_we_q ? '0 : bus.mem_rdata;
          end else if (expired) begin
            state_q         <= DRAIN;
            m_fault_q       <= 1'b1;
            err_count_q     <= err_count_d;
            last_err_addr_q <= mem_addr_q;
            timer_q         <= '0;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end

        RESP, FAULT: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end

        DRAIN: begin
          // Orphan response (or second timeout) ends the drain; its data is dropped.
          if (bus.mem_rvalid || expired) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end

        default: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m_rdata       = m_rdata_q;
  assign bus.m_rvalid      = m_rvalid_q;
  assign bus.m_fault       = m_fault_q;
  assign bus.mem_req       = mem_req_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_be        = mem_be_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.busy          = busy_q;
  assign bus.err_count     = err_count_q;
  assign bus.last_err_addr = last_err_addr_q;

endmodule
